tap_tempo: RTL and testbench

Tempo receiver and measurer: the inverse of the `tempo` generator. Takes a raw beat input (user button or an external quarter-note line on an IO pin), debounces it, measures the interval between beats, and averages the last four valid intervals into a beat period in clock cycles. Once locked, it regenerates a phase-aligned one-cycle quarter pulse. Sits between a top-level input pin and any tempo-synchronised logic in `main`.

---
 rtl/tap_tempo.sv | 240 ++++++++++++++++++++++++
 tb/tb_tap_tempo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_tempo.sv
// ----------------------------------------------------------------------------
// tap_tempo
// Tempo receiver: debounces a raw beat input, measures the cycle distance
// between beats, averages the last four valid intervals into a beat period
// and, once locked, regenerates a phase-aligned one-cycle quarter pulse.
//
// Ports
//   clock_in      in   1  sole clock
//   reset         in   1  asynchronous active-high reset, clears all state
//   tap_in        in   1  raw asynchronous beat input, active-high
//   tap_detected  out  1  one-cycle pulse per debounced rising edge
//   locked        out  1  high while four consecutive valid intervals are held
//   period        out 32  averaged beat period in cycles (valid while locked)
//   beat          out  1  regenerated one-cycle quarter pulse (only while locked)
// ----------------------------------------------------------------------------
module tap_tempo #(
    parameter int unsigned CLK_HZ   = 49152000,
    parameter int unsigned MIN_BPM  = 30,
    parameter int unsigned MAX_BPM  = 300,
    parameter int unsigned DEBOUNCE = 49152
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        tap_in,
    output logic        tap_detected,
    output logic        locked,
    output logic [31:0] period,
    output logic        beat
);

    // Interval bounds in clock cycles, computed in 64 bits to avoid overflow
    localparam logic [31:0] MIN_INTERVAL  = 32'((64'(CLK_HZ) * 64'd60) / 64'(MAX_BPM));
    localparam logic [31:0] MAX_INTERVAL  = 32'((64'(CLK_HZ) * 64'd60) / 64'(MIN_BPM));
    localparam logic [31:0] TIMEOUT_COUNT = MAX_INTERVAL + 32'd1;

    // Debounce counter runs 0 .. DEBOUNCE-1
    localparam int unsigned   DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    localparam logic [2:0] VALID_FULL = 3'd4;
    localparam logic [2:0] VALID_LAST = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Input path: synchroniser, debouncer, edge detector
    // ------------------------------------------------------------------------
    logic            r_sync1;
    logic            r_sync2;
    logic            r_deb;
    logic            r_deb_d;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_edge;

    // Level flips only after DEBOUNCE consecutive disagreeing samples
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_deb    <= 1'b0;
            r_deb_d  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= tap_in;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (r_sync2 != r_deb) begin
                if (r_db_cnt == DB_LAST) begin
                    r_deb    <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_edge = r_deb & ~r_deb_d;

    // ------------------------------------------------------------------------
    // Measurement state
    // ------------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_count;
    logic [2:0]        r_valid;
    // Three most recent accepted intervals; the fourth is the one being accepted
    logic [2:0][31:0]  r_hist;
    logic [31:0]       r_phase;
    logic              r_tap_det;
    logic              r_locked;
    logic [31:0]       r_period;
    logic              r_beat;

    logic              w_timeout;
    logic              w_in_window;
    logic              w_accept;
    logic              w_restart;
    logic              w_phase_hit;
    logic [33:0]       w_sum;

    logic [31:0]       w_count_next;
    logic [2:0]        w_valid_next;
    logic [2:0][31:0]  w_hist_next;
    logic [31:0]       w_phase_next;
    logic              w_tap_det_next;
    logic              w_locked_next;
    logic [31:0]       w_period_next;
    logic              w_beat_next;

    // Edge classification; a timeout always wins over an accept
    assign w_timeout   = (r_state != S_IDLE) && (r_count == TIMEOUT_COUNT);
    assign w_in_window = (r_count >= MIN_INTERVAL) && (r_count <= MAX_INTERVAL);
    assign w_accept    = w_edge && (r_state != S_IDLE) && !w_timeout && w_in_window;
    assign w_restart   = w_edge && ((r_state == S_IDLE) || w_timeout);
    assign w_phase_hit = (r_state == S_LOCKED) && (r_phase == r_period);

    // Sum of the four newest intervals once the current one is pushed
    assign w_sum = 34'(r_count) + 34'(r_hist[0]) + 34'(r_hist[1]) + 34'(r_hist[2]);

    // State register
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_state_next = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (w_timeout) begin
                    w_state_next = w_edge ? S_MEASURE : S_IDLE;
                end else if (w_accept && (r_valid == VALID_LAST)) begin
                    w_state_next = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (w_timeout) begin
                    w_state_next = w_edge ? S_MEASURE : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values
    always_comb begin
        w_count_next   = r_count;
        w_valid_next   = r_valid;
        w_hist_next    = r_hist;
        w_phase_next   = r_phase;
        w_period_next  = r_period;
        w_beat_next    = 1'b0;
        w_tap_det_next = w_edge;
        w_locked_next  = (w_state_next == S_LOCKED);

        // Interval counter: restarts on a first or accepted edge, saturates
        if (w_state_next == S_IDLE) begin
            w_count_next = '0;
        end else if (w_restart || w_accept) begin
            w_count_next = 32'd1;
        end else if (r_count != TIMEOUT_COUNT) begin
            w_count_next = r_count + 32'd1;
        end

        // History and valid count
        if (w_timeout || w_restart) begin
            w_valid_next = '0;
            w_hist_next  = '0;
        end else if (w_accept) begin
            w_hist_next = {r_hist[1:0], r_count};
            if (r_valid != VALID_FULL) begin
                w_valid_next = r_valid + 3'd1;
            end
        end

        // Average refreshed only on an edge that leaves us locked
        if (w_accept && (w_state_next == S_LOCKED)) begin
            w_period_next = 32'(w_sum >> 2);
        end

        // Beat regeneration: an accepted edge and a phase match share one pulse
        if (w_state_next == S_LOCKED) begin
            if (w_accept || w_phase_hit) begin
                w_phase_next = 32'd1;
                w_beat_next  = 1'b1;
            end else begin
                w_phase_next = r_phase + 32'd1;
            end
        end else begin
            w_phase_next = '0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_valid   <= '0;
            r_hist    <= '0;
            r_phase   <= '0;
            r_tap_det <= 1'b0;
            r_locked  <= 1'b0;
            r_period  <= '0;
            r_beat    <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_valid   <= w_valid_next;
            r_hist    <= w_hist_next;
            r_phase   <= w_phase_next;
            r_tap_det <= w_tap_det_next;
            r_locked  <= w_locked_next;
            r_period  <= w_period_next;
            r_beat    <= w_beat_next;
        end
    end

    assign tap_detected = r_tap_det;
    assign locked       = r_locked;
    assign period       = r_period;
    assign beat         = r_beat;

endmodule

// File: tb/tb_tap_tempo.sv
// ----------------------------------------------------------------------------
// tb_tap_tempo
// Directed scenarios plus randomized tap trains for tap_tempo. A timestamp
// model predicts every output on every cycle from the list of expected
// debounced edge times; literal checks pin a few hand-computed values.
// ----------------------------------------------------------------------------
module tb_tap_tempo;

    localparam int DEB    = 4;
    localparam int MIN_IV = 200;
    localparam int MAX_IV = 2000;
    localparam int M_IDLE = 0;
    localparam int M_MEAS = 1;
    localparam int M_LOCK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tap = 1'b0;
    logic        tdet;
    logic        lck;
    logic        bt;
    logic [31:0] per;

    int total  = 0;
    int bad    = 0;
    int cyc    = 0;
    int last_r = 0;

    // Cycle numbers on which a debounced rising edge is due
    int edge_q[$];

    // Model state: times in cycles, intervals as plain integers
    int   m_st;
    int   m_start;
    int   m_nval;
    int   m_next_beat;
    int   m_hist[4];
    logic e_tdet;
    logic e_lck;
    logic e_beat;
    int   e_per;

    tap_tempo #(
        .CLK_HZ  (1000),
        .MIN_BPM (30),
        .MAX_BPM (300),
        .DEBOUNCE(4)
    ) dut (
        .clock_in    (clk),
        .reset       (rst),
        .tap_in      (tap),
        .tap_detected(tdet),
        .locked      (lck),
        .period      (per),
        .beat        (bt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_st        = M_IDLE;
        m_start     = 0;
        m_nval      = 0;
        m_next_beat = 0;
        for (int i = 0; i < 4; i++) m_hist[i] = 0;
        e_tdet = 1'b0;
        e_lck  = 1'b0;
        e_beat = 1'b0;
        e_per  = 0;
        edge_q.delete();
    endtask

    // Decide what cycle c does; results are the outputs seen in cycle c+1
    task automatic model_step(input int c);
        bit ev;
        int el;
        ev = 1'b0;
        if (edge_q.size() > 0 && edge_q[0] == c) begin
            ev = 1'b1;
            void'(edge_q.pop_front());
        end
        el     = c - m_start;
        e_tdet = ev;
        e_beat = 1'b0;
        if (m_st == M_IDLE) begin
            if (ev) begin
                m_st    = M_MEAS;
                m_start = c;
                m_nval  = 0;
            end
        end else if (el == MAX_IV + 1) begin
            m_nval = 0;
            for (int i = 0; i < 4; i++) m_hist[i] = 0;
            if (ev) begin
                m_st    = M_MEAS;
                m_start = c;
            end else begin
                m_st = M_IDLE;
            end
        end else if (ev && el >= MIN_IV && el <= MAX_IV) begin
            for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = el;
            if (m_nval < 4) m_nval++;
            m_start = c;
            if (m_nval == 4) begin
                m_st        = M_LOCK;
                e_per       = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
                e_beat      = 1'b1;
                m_next_beat = c + 1 + e_per;
            end
        end else if (m_st == M_LOCK && c + 1 == m_next_beat) begin
            e_beat      = 1'b1;
            m_next_beat = m_next_beat + e_per;
        end
        e_lck = (m_st == M_LOCK);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            chk("rst_tap_detected", 64'(tdet), 64'd0);
            chk("rst_locked",       64'(lck),  64'd0);
            chk("rst_period",       64'(per),  64'd0);
            chk("rst_beat",         64'(bt),   64'd0);
        end else begin
            chk("tap_detected", 64'(tdet), 64'(e_tdet));
            chk("locked",       64'(lck),  64'(e_lck));
            chk("period",       64'(per),  64'(e_per));
            chk("beat",         64'(bt),   64'(e_beat));
            model_step(cyc);
        end
    end

    task automatic step_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) step_neg();
    endtask

    // Clean pulse of w sampled cycles; registers only when w >= DEB
    task automatic pulse(input int w);
        if (w >= DEB) edge_q.push_back(cyc + DEB + 2);
        tap = 1'b1;
        repeat (w) step_neg();
        tap = 1'b0;
    endtask

    task automatic tap_after(input int iv, input int w);
        while (cyc < last_r + iv) step_neg();
        last_r = cyc;
        pulse(w);
    endtask

    task automatic tap_extra(input int off);
        while (cyc < last_r + off) step_neg();
        pulse(6);
    endtask

    task automatic glitch_at(input int off, input int w);
        while (cyc < last_r + off) step_neg();
        tap = 1'b1;
        repeat (w) step_neg();
        tap = 1'b0;
    endtask

    initial begin
        wait_cyc(3);
        chk("lit_reset_locked", 64'(lck), 64'd0);
        chk("lit_reset_period", 64'(per), 64'd0);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(20);

        // Steady taps every 500
        last_r = cyc;
        pulse(6);
        for (int i = 0; i < 4; i++) tap_after(500, 6);
        wait_cyc(20);
        chk("lit_lock500",   64'(lck), 64'd1);
        chk("lit_period500", 64'(per), 64'd500);

        // Intervals 400,500,600,501 then 1000
        tap_after(400, 6);
        tap_after(500, 6);
        tap_after(600, 6);
        tap_after(501, 6);
        wait_cyc(20);
        chk("lit_period2001", 64'(per), 64'd500);
        tap_after(1000, 6);
        wait_cyc(20);
        chk("lit_period650", 64'(per), 64'd650);

        // Too-early tap and a short glitch leave the average alone
        tap_extra(100);
        wait_cyc(20);
        chk("lit_extra_period", 64'(per), 64'd650);
        chk("lit_extra_locked", 64'(lck), 64'd1);
        glitch_at(250, 2);
        for (int i = 0; i < 4; i++) tap_after(500, 6);
        wait_cyc(20);
        chk("lit_back500", 64'(per), 64'd500);

        // Taps stop: timeout drops lock, period holds
        while (cyc < last_r + 2100) step_neg();
        chk("lit_timeout_locked", 64'(lck), 64'd0);
        chk("lit_timeout_period", 64'(per), 64'd500);

        // Edge landing on the timeout cycle restarts measurement
        tap_after(2200, 6);
        tap_after(2001, 6);
        for (int i = 0; i < 3; i++) tap_after(500, 6);
        wait_cyc(20);
        chk("lit_not_yet_locked", 64'(lck), 64'd0);
        tap_after(500, 6);
        wait_cyc(20);
        chk("lit_relock", 64'(lck), 64'd1);

        // Asynchronous reset while locked
        wait_cyc(30);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("lit_async_tap_detected", 64'(tdet), 64'd0);
        chk("lit_async_locked",       64'(lck),  64'd0);
        chk("lit_async_period",       64'(per),  64'd0);
        chk("lit_async_beat",         64'(bt),   64'd0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(10);
        last_r = cyc;
        pulse(6);
        for (int i = 0; i < 4; i++) tap_after(300, 6);
        wait_cyc(20);
        chk("lit_period300", 64'(per), 64'd300);
        chk("lit_lock300",   64'(lck), 64'd1);

        // Interval bounds: 200 and 2000 accepted, 199 ignored
        tap_after(200, DEB);
        tap_after(2000, 6);
        wait_cyc(20);
        chk("lit_period700", 64'(per), 64'd700);
        tap_extra(199);
        wait_cyc(20);
        chk("lit_ignore199", 64'(per), 64'd700);
        tap_after(400, 6);
        wait_cyc(20);
        chk("lit_period725", 64'(per), 64'd725);

        // Randomized trains with glitches, short and overlong intervals
        for (int i = 0; i < 40; i++) begin
            int k;
            int iv;
            k = $urandom_range(0, 99);
            if (k < 70)      iv = $urandom_range(200, 1200);
            else if (k < 85) iv = $urandom_range(100, 199);
            else             iv = $urandom_range(2001, 2100);
            if ($urandom_range(0, 4) == 0) glitch_at(50, $urandom_range(1, DEB - 1));
            tap_after(iv, $urandom_range(DEB, 12));
        end
        wait_cyc(2200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
